uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ independent byte sources using round-robin arbitration. Each requester gets a valid/ready handshake. The arbiter drives the serializer's tx_din/tx_din_vld pair and tracks its busy output to find frame boundaries. It sits between the application clients (status reporters, echo logic, debug dump) and the uart_tx instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must equal clog2(N_REQ)
BUSY_WAIT_MAX, 8, clock cycles to wait for busy to rise after tx_din_vld before the frame is declared lost
GAP_CYC, 0, idle clock cycles inserted after busy falls and before the next grant (0..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req_data  input  N_REQ*8  requester bytes; requester i uses bits [8i+7:8i]
req_vld  input  N_REQ  requester i holds a byte; once asserted, vld and data stay stable until accepted
req_rdy  output  N_REQ  one-hot accept strobe; a byte is taken in the cycle where req_vld[i] and req_rdy[i] are both high
tx_din  output  8  byte to uart_tx, registered
tx_din_vld  output  1  one-cycle start pulse to uart_tx
busy  input  1  uart_tx busy flag
grant_id  output  ID_W  index of the requester whose byte is in flight
active  output  1  high from ISSUE through GAP
frame_done  output  1  one-cycle pulse when busy falls for the current frame
err_nobusy  output  1  one-cycle pulse when busy does not rise within BUSY_WAIT_MAX cycles

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, and all of tx_din, tx_din_vld, grant_id, active, frame_done, err_nobusy = 0. req_rdy=0 while rst is high.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any req_vld is high, the winner g is the first set bit found scanning upward (with wrap) from rr_ptr.
  - req_rdy[g]=1 combinationally in that cycle; all other req_rdy bits are 0.
  - At the clock edge: tx_din<=req_data[g], grant_id<=g, rr_ptr<=(g+1) mod N_REQ, state->ISSUE.
  - req_rdy is 0 in every state other than IDLE.
- ISSUE (1 cycle): tx_din_vld=1 and active=1; clear the wait counter; ->WAIT_BUSY. tx_din_vld is high for exactly this one cycle.
- WAIT_BUSY:
  - busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_WAIT_MAX with busy still 0, pulse err_nobusy and go to GAP; frame_done is not pulsed.
- WAIT_DONE: stay while busy=1. On busy=0, pulse frame_done in that cycle and go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE. If GAP_CYC=0, GAP still lasts 1 cycle so the serializer sees busy low before the next start.
- active=1 in ISSUE, WAIT_BUSY, WAIT_DONE and GAP; 0 in IDLE.
- Minimum latency: req_vld rising in IDLE gives req_rdy in the same cycle and tx_din_vld one cycle later.
- Round-robin fairness: a requester that keeps vld asserted continuously is served within N_REQ frames.
- A requester re-asserting right after being served gets the lowest priority next round.
- Changes on req_vld while not in IDLE are ignored; they are arbitrated at the next IDLE.
- busy already high when entering WAIT_BUSY (back-to-back serializer) is treated as the rise; the arbiter does not attempt edge detection there.
- Reset mid-frame forces IDLE immediately. A partially sent frame on the line is the serializer's concern. The byte held by the arbiter is discarded, and the requester is not re-served because its handshake already completed.
- grant_id and tx_din hold their value after the frame until the next grant.

Test Plan:
- Single requester: req_vld[0]=1, data 8'hAA, busy modelled high 3 cycles after start for 100 cycles -> req_rdy[0] for 1 cycle, tx_din=8'hAA, tx_din_vld 1 cycle later, frame_done when busy falls, grant_id=0.
- Simultaneous: req_vld=4'b0110 with 8'h55 on req 1 and 8'hEF on req 2 -> req 1 served first, then req 2; tx_din sequence 55, EF; rr_ptr=3 afterwards.
- Fairness: all four requesters hold vld continuously (re-assert after each accept) for 8 frames -> grant order 0,1,2,3,0,1,2,3; no frame overlap, since tx_din_vld never occurs while busy=1.
- Lost frame: busy tied 0, BUSY_WAIT_MAX=8 -> err_nobusy pulses 9 cycles after tx_din_vld, no frame_done, then return to IDLE and serve the next request.
- Gap: GAP_CYC=5, two queued requests -> exactly 5 cycles between frame_done and the next req_rdy.
- Reset mid-frame: assert rst during WAIT_DONE -> all outputs 0 asynchronously. After release, a pending req_vld[3] is served with grant_id=3 and rr_ptr restarted from 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte requesters, round-robin arbiter and uart_tx start/busy pair.
// master is the arbiter side; slave is the side that drives requests and busy.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ-1:0]   req_vld;
    logic [N_REQ-1:0]   req_rdy;
    logic [7:0]         tx_din;
    logic               tx_din_vld;
    logic               busy;
    logic [ID_W-1:0]    grant_id;
    logic               active;
    logic               frame_done;
    logic               err_nobusy;

    modport master (
        input  req_data, req_vld, busy,
        output req_rdy, tx_din, tx_din_vld,
        output grant_id, active,
        output frame_done, err_nobusy
    );

    modport slave (
        output req_data, req_vld, busy,
        input  req_rdy, tx_din, tx_din_vld,
        input  grant_id, active,
        input  frame_done, err_nobusy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte sources.
// Frame boundaries come from the serializer busy flag.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int ID_W          = 2,
    parameter int BUSY_WAIT_MAX = 8,
    parameter int GAP_CYC       = 0
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'(BUSY_WAIT_MAX);
    // A zero gap still spends one cycle so busy is seen low.
    localparam logic [CNT_W-1:0] GAP_LAST =
        (GAP_CYC == 0) ? '0 : CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [7:0]        r_tx_din;
    logic [ID_W-1:0]   r_grant_id;

    logic              w_any;
    logic [ID_W-1:0]   w_win;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [N_REQ-1:0]  w_rdy;
    logic              w_start;
    logic              w_done;
    logic              w_err;
    int                w_idx;

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_any && bus.req_vld[ID_W'(w_idx)]) begin
                w_any = 1'b1;
                w_win = ID_W'(w_idx);
            end
        end
    end

    assign w_ptr_nxt = (w_win == ID_W'(N_REQ - 1)) ?
        '0 : w_win + ID_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = '0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_rdy       = N_REQ'(1) << w_win;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Busy already high here counts as the rise.
                if (bus.busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == WAIT_LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt >= GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_tx_din   <= '0;
            r_grant_id <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_IDLE && w_any) begin
                r_tx_din   <= bus.req_data[{w_win, 3'b000} +: 8];
                r_grant_id <= w_win;
                r_rr_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign bus.req_rdy    = rst ? '0 : w_rdy;
    assign bus.tx_din     = r_tx_din;
    assign bus.tx_din_vld = w_start;
    assign bus.grant_id   = r_grant_id;
    assign bus.active     = (r_state != S_IDLE);
    assign bus.frame_done = w_done;
    assign bus.err_nobusy = w_err;
endmodule
